// File: rtl/uc_pkg.sv
// Shared definitions for the microcontroller sequencing unit:
// opcode constants, the ALU pass-B code, state encoding and the decoded control bundle.
package uc_pkg;

    localparam logic [3:0] OP_LI_PFX  = 4'b0000;
    localparam logic [5:0] OP_J       = 6'b000100;
    localparam logic [5:0] OP_JZ      = 6'b000101;
    localparam logic [5:0] OP_JNZ     = 6'b000110;
    localparam logic [5:0] OP_NOP     = 6'b001000;
    localparam logic [5:0] OP_HALT    = 6'b001111;

    localparam logic [2:0] ALU_PASS_B = 3'b000;

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUN     = 1'b1
    } state_e;

    typedef struct packed {
        logic       s_inc;
        logic       s_inm;
        logic       we;
        logic       wez;
        logic [2:0] alu_op;
        logic       is_halt;
        logic       legal;
    } ctrl_t;

    // Bundle for an instruction that only advances the PC (NOP, HALT, undefined codes).
    function automatic ctrl_t ctrl_nop();
        ctrl_t c;
        c.s_inc   = 1'b1;
        c.s_inm   = 1'b0;
        c.we      = 1'b0;
        c.wez     = 1'b0;
        c.alu_op  = ALU_PASS_B;
        c.is_halt = 1'b0;
        c.legal   = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/uc_decode.sv
// Combinational opcode decoder: maps the 6-bit opcode and the registered zero
// flag onto the datapath control bundle, flagging undefined opcodes.
module uc_decode
    import uc_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic       i_zq,
    output ctrl_t      o_ctrl
);

    // Opcode to control-bundle decode.
    always_comb begin
        o_ctrl = ctrl_nop();
        if (i_opcode[5]) begin
            o_ctrl.alu_op = i_opcode[4:2];
            o_ctrl.we     = 1'b1;
            o_ctrl.wez    = 1'b1;
        end else if (i_opcode[5:2] == OP_LI_PFX) begin
            o_ctrl.alu_op = ALU_PASS_B;
            o_ctrl.s_inm  = 1'b1;
            o_ctrl.we     = 1'b1;
        end else begin
            case (i_opcode)
                OP_J:    o_ctrl.s_inc   = 1'b0;
                OP_JZ:   o_ctrl.s_inc   = ~i_zq;
                OP_JNZ:  o_ctrl.s_inc   = i_zq;
                OP_NOP:  o_ctrl.s_inc   = 1'b1;
                OP_HALT: o_ctrl.is_halt = 1'b1;
                default: o_ctrl.legal   = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/uc_sequencer.sv
// Sequencing control unit: run/stop/single-step control, commit gating of the
// decoded write enables, registered zero flag, sticky illegal flag and retire counter.
module uc_sequencer
    import uc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic             zero,
    input  logic             run_req,
    input  logic             halt_req,
    input  logic             step_req,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we,
    output logic             wez,
    output logic [2:0]       ALUOp,
    output logic             pc_en,
    output logic             running,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_e           r_state;
    logic             r_zq;
    logic             r_illegal;
    logic [CNT_W-1:0] r_retired;
    ctrl_t            w_ctrl;
    logic             w_commit;

    uc_decode u_decode (
        .i_opcode (Opcode),
        .i_zq     (r_zq),
        .o_ctrl   (w_ctrl)
    );

    // Reset gates commit directly so enables drop without waiting for a clock edge.
    assign w_commit = reset & (((r_state == ST_RUN) & ~halt_req) |
                               ((r_state == ST_STOPPED) & step_req));

    assign s_inc   = w_ctrl.s_inc;
    assign s_inm   = w_ctrl.s_inm;
    assign ALUOp   = w_ctrl.alu_op;
    assign we      = w_ctrl.we  & w_commit;
    assign wez     = w_ctrl.wez & w_commit;
    assign pc_en   = w_commit;
    assign running = (r_state == ST_RUN);
    assign illegal = r_illegal;
    assign retired = r_retired;

    // Run/stop state machine plus the per-commit state: zero flag, illegal flag, counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_STOPPED;
            r_zq      <= 1'b0;
            r_illegal <= 1'b0;
            r_retired <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                ST_STOPPED: begin
                    if (run_req && !halt_req) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_STOPPED;
                    end
                end
                ST_RUN: begin
                    if (halt_req || (w_commit && w_ctrl.is_halt)) begin
                        r_state <= ST_STOPPED;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_STOPPED;
            endcase

            if (w_commit) begin
                r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
                if (w_ctrl.wez) begin
                    r_zq <= zero;
                end else begin
                    r_zq <= r_zq;
                end
                if (!w_ctrl.legal) begin
                    r_illegal <= 1'b1;
                end else begin
                    r_illegal <= r_illegal;
                end
            end else begin
                r_retired <= r_retired;
                r_zq      <= r_zq;
                r_illegal <= r_illegal;
            end
        end
    end

endmodule

// File: doc/uc_sequencer.md
# uc_sequencer

Sequencing control unit for the single-cycle 8-bit microcontroller datapath. Decodes the 6-bit `Opcode`, drives the datapath selects, write enables and `ALUOp`, and owns run/stop/single-step control through a PC enable. Keeps the registered zero flag used for conditional jumps and counts retired instructions. Sits between the debug/host control pins and the datapath.

## Interface
- `CNT_W`, 16, width of the retired-instruction counter
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `Opcode`  in  6  instruction[15:10] from program memory
- `zero`  in  1  ALU zero output for the current instruction
- `run_req`  in  1  level; request free-running execution
- `halt_req`  in  1  level; request stop
- `step_req`  in  1  single-cycle pulse; execute exactly one instruction while stopped
- `s_inc`  out  1  1 = PC+1, 0 = jump address
- `s_inm`  out  1  1 = immediate operand / WA3 as read port 1
- `we`  out  1  register file write enable
- `wez`  out  1  zero-flag write enable
- `ALUOp`  out  3  ALU operation
- `pc_en`  out  1  PC register load enable
- `running`  out  1  state == RUN
- `illegal`  out  1  sticky; an undefined opcode committed
- `retired`  out  CNT_W  committed instruction count

## Operation
- Decode on `Opcode[5:2]` / full `Opcode`:
  - `1ooo xx`: ALU reg-reg; `ALUOp`=ooo, `s_inm`=0, `we`=1, `wez`=1, `s_inc`=1
  - `0000 xx`: load immediate; `ALUOp`=000 (pass B), `s_inm`=1, `we`=1, `wez`=0, `s_inc`=1
  - `000100` J: `s_inc`=0; `000101` JZ: `s_inc`=~z_q; `000110` JNZ: `s_inc`=z_q
  - `001000` NOP; `001111` HALT; all other codes: executed as NOP, set `illegal`
- States: STOPPED (reset state), RUN.
- commit = (RUN & ~halt_req) | (STOPPED & step_req).
- `we`, `wez`, `pc_en` are decode value AND commit; `s_inc`, `s_inm`, `ALUOp` are pure decode (don't-care when not committing).
- Transitions: STOPPED→RUN when run_req & ~halt_req; RUN→STOPPED when halt_req, or on committed HALT; otherwise hold.
- HALT commits with `pc_en`=1, `s_inc`=1: PC advances past HALT, resume continues at next instruction.
- step_req and run_req together in STOPPED: instruction commits, next state RUN. step_req in RUN: ignored.
- z_q <= `zero` when commit & `wez`; JZ/JNZ test z_q, so a jump directly after an ALU op sees that op's result.
- `retired` increments by 1 per commit, wraps 2^CNT_W−1 → 0.
- `illegal` set on commit of an undefined code; cleared only by reset.

## Timing
- Reset (async assert, sync-safe deassert): state=STOPPED, z_q=0, `retired`=0, `illegal`=0, `running`=0; hence `we`=`wez`=`pc_en`=0.
- First instruction after reset commits no earlier than the cycle after run_req is sampled high, or in the cycle step_req is high.
- Decode is combinational, zero-latency from `Opcode`; all state updates at the commit edge.
- halt_req high in RUN blocks commit in that same cycle (no write, PC held).
- Reset asserted mid-run: all enables drop immediately (asynchronous), nothing commits.

## Structure
- Shared package/header `uc_pkg`: opcode constants (J, JZ, JNZ, NOP, HALT, LI prefix), ALUOp pass-B code, state encoding.
- Sub-module `uc_decode`: purely combinational opcode → control-bundle + legal flag; the sequencer adds state, commit gating, z_q, counter.

## Test plan
- Reset then run_req=1, program LI r1,5; ADD; NOP -> `we` high on cycles 1–2, `retired`=3 after third commit, `running`=1.
- ALU op giving zero then JZ 0x040 -> `s_inc`=0, `pc_en`=1; with nonzero result -> `s_inc`=1.
- HALT at PC 7 while running -> commits, `running`=0 next cycle, `pc_en`=0 thereafter, `retired` incremented once.
- STOPPED, three step_req pulses 4 cycles apart -> exactly three commits, `retired`=+3, state stays STOPPED.
- Opcode 6'b001010 committed -> `we`=`wez`=0, `illegal`=1 held until reset.
- Reset asserted while RUN with `we`=1 -> `we`, `pc_en` drop without clock edge, `retired`=0, `illegal`=0.
